// File: rtl/fifo_stream_reader_if.sv
// FIFO read port plus valid/ready output stream for the stream reader.
// master: the reader (pops the FIFO, drives the stream).
// slave:  the surrounding FIFO and downstream consumer.
interface fifo_stream_reader_if #(
   parameter int DATA_W = 8
) ();
   logic              fifo_valid;
   logic [DATA_W-1:0] fifo_dataout;
   logic              fifo_enr;
   logic [DATA_W-1:0] m_tdata;
   logic              m_tvalid;
   logic              m_tready;
   logic              m_tlast;

   modport master (
      input  fifo_valid, fifo_dataout, m_tready,
      output fifo_enr, m_tdata, m_tvalid, m_tlast
   );

   modport slave (
      output fifo_valid, fifo_dataout, m_tready,
      input  fifo_enr, m_tdata, m_tvalid, m_tlast
   );
endinterface

// File: rtl/fifo_stream_reader.sv
// Read-side controller for the shift-register FIFO: pops a programmed number
// of words and presents them as a valid/ready stream with tlast.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | issuing paced pops until len words have been popped
// DRAIN | all pops issued, waiting for the last beat to be accepted
// DONE  | one-cycle done pulse, then back to IDLE
module fifo_stream_reader #(
   parameter int DATA_W = 8,
   parameter int LEN_W  = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [LEN_W-1:0] len,
   input  logic             abort,
   output logic             busy,
   output logic             done,
   output logic [LEN_W-1:0] count,
   fifo_stream_reader_if.master bus
);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   state_t            state, state_nxt;
   logic [LEN_W-1:0]  len_q;
   logic [LEN_W-1:0]  issued;
   logic              pop_d;
   logic [1:0]        occ;
   logic [DATA_W-1:0] buf0, buf1;

   logic push, pop, abort_c, start_ok, last_acc, pop_ok;

   assign push     = bus.fifo_enr;
   assign pop      = bus.m_tvalid && bus.m_tready;
   assign abort_c  = abort && (state != IDLE);
   // abort wins over a coincident start
   assign start_ok = (state == IDLE) && start && !abort;
   assign last_acc = pop && (count == len_q - LEN_W'(1));
   // the FIFO valid flag lags a pop by a cycle, so a pop in flight (pop_d)
   // still counts against the two skid slots
   assign pop_ok   = ({1'b0, occ} + {2'b00, pop_d}) < 3'd2;

   // state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   // next-state decode
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:  if (start_ok) state_nxt = (len == '0) ? DONE : RUN;
         RUN:   if (abort)                state_nxt = IDLE;
                else if (last_acc)        state_nxt = DONE;
                else if (issued == len_q) state_nxt = DRAIN;
         DRAIN: if (abort)                state_nxt = IDLE;
                else if (last_acc)        state_nxt = DONE;
         DONE:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // outputs: status, paced pop strobe, stream from skid head
   always_comb begin
      busy         = (state != IDLE);
      done         = (state == DONE);
      bus.fifo_enr = (state == RUN) && bus.fifo_valid && !pop_d &&
                     (issued < len_q) && pop_ok;
      bus.m_tvalid = (occ != 2'd0);
      bus.m_tdata  = buf0;
      bus.m_tlast  = (occ != 2'd0) && (count == len_q - LEN_W'(1));
   end

   // length latch, pop/beat counters and pop pacing
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         len_q  <= '0;
         count  <= '0;
         issued <= '0;
         pop_d  <= 1'b0;
      end else begin
         pop_d <= push;
         if (start_ok) begin
            len_q  <= len;
            count  <= '0;
            issued <= '0;
         end else if (!abort_c) begin
            if (push) issued <= issued + LEN_W'(1);
            if (pop)  count  <= count + LEN_W'(1);
         end
      end
   end

   // 2-entry skid buffer, buf0 is the head; push and pop may coincide
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         occ  <= 2'd0;
         buf0 <= '0;
         buf1 <= '0;
      end else if (abort_c) begin
         occ <= 2'd0;
      end else begin
         case ({push, pop})
            2'b10: begin
               if (occ == 2'd0) buf0 <= bus.fifo_dataout;
               else             buf1 <= bus.fifo_dataout;
               occ <= occ + 2'd1;
            end
            2'b01: begin
               buf0 <= buf1;
               occ  <= occ - 2'd1;
            end
            2'b11: begin
               if (occ == 2'd1) begin
                  buf0 <= bus.fifo_dataout;
               end else begin
                  buf0 <= buf1;
                  buf1 <= bus.fifo_dataout;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench for fifo_stream_reader: a behavioural FIFO feeds the DUT,
// expected beats go into a scoreboard queue, a monitor compares accepted beats.
module tb_fifo_stream_reader;
   localparam int DATA_W = 8;
   localparam int LEN_W  = 16;

   typedef struct packed {
      logic [DATA_W-1:0] d;
      logic              last;
   } beat_t;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             start = 1'b0;
   logic [LEN_W-1:0] len = '0;
   logic             abort = 1'b0;
   logic             busy, done;
   logic [LEN_W-1:0] count;

   logic              push_en = 1'b0;
   logic [DATA_W-1:0] push_data = '0;
   logic              fifo_clr = 1'b0;
   logic [DATA_W-1:0] fq[$];
   beat_t             exp_q[$];

   int vectors = 0;
   int miscompares = 0;

   fifo_stream_reader_if #(.DATA_W(DATA_W)) bus ();

   fifo_stream_reader #(.DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .len   (len),
      .abort (abort),
      .busy  (busy),
      .done  (done),
      .count (count),
      .bus   (bus.master)
   );

   always #5 clk = ~clk;

   // behavioural FIFO: registered valid/head, pop on fifo_enr
   always @(posedge clk) begin
      if (fifo_clr) begin
         fq.delete();
      end else begin
         if (bus.fifo_enr && fq.size() > 0) void'(fq.pop_front());
         if (push_en) fq.push_back(push_data);
      end
      bus.fifo_valid   <= (fq.size() != 0);
      bus.fifo_dataout <= (fq.size() != 0) ? fq[0] : '0;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // monitor: every accepted beat is compared with the scoreboard head
   initial begin
      beat_t e;
      logic  prev_last;
      prev_last = 1'b0;
      forever begin
         @(negedge clk);
         if (prev_last) check("done_after_tlast", {31'd0, done}, 32'd1);
         prev_last = 1'b0;
         if (rst && bus.m_tvalid && bus.m_tready) begin
            if (exp_q.size() == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL unexpected_beat: got data 0x%0h, expected no beat", bus.m_tdata);
            end else begin
               e = exp_q.pop_front();
               check("tdata", {24'd0, bus.m_tdata}, {24'd0, e.d});
               check("tlast", {31'd0, bus.m_tlast}, {31'd0, e.last});
               prev_last = bus.m_tlast;
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_word(input logic [DATA_W-1:0] d, input logic last, input logic expect_beat);
      push_en   = 1'b1;
      push_data = d;
      if (expect_beat) exp_q.push_back('{d: d, last: last});
      tick();
      push_en = 1'b0;
   endtask

   task automatic do_start(input logic [LEN_W-1:0] l);
      start = 1'b1;
      len   = l;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_done(input string name, input int budget);
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < budget && !seen; i++) begin
         @(negedge clk);
         if (done) seen = 1'b1;
      end
      check(name, {31'd0, seen}, 32'd1);
      tick();
   endtask

   task automatic clear_fifo();
      fifo_clr = 1'b1;
      tick();
      fifo_clr = 1'b0;
      tick();
   endtask

   initial begin
      logic [6:0]        enrv, donev, tvv;
      logic [2:0]        zdone;
      logic              any, all_busy, stable, seen3;
      logic [DATA_W-1:0] first_d;
      int                pops;

      bus.m_tready = 1'b1;

      // reset state
      #2;
      check("rst_busy",   {31'd0, busy}, 32'd0);
      check("rst_done",   {31'd0, done}, 32'd0);
      check("rst_count",  {16'd0, count}, 32'd0);
      check("rst_enr",    {31'd0, bus.fifo_enr}, 32'd0);
      check("rst_tvalid", {31'd0, bus.m_tvalid}, 32'd0);
      check("rst_tlast",  {31'd0, bus.m_tlast}, 32'd0);
      check("rst_tdata",  {24'd0, bus.m_tdata}, 32'd0);
      tick();
      tick();
      rst = 1'b1;
      tick();

      // basic: pops at cycles 1,3,5, beats at 2,4,6, done at 7
      push_word(8'h11, 1'b0, 1'b1);
      push_word(8'h22, 1'b0, 1'b1);
      push_word(8'h33, 1'b1, 1'b1);
      tick();
      tick();
      do_start(16'd3);
      for (int c = 0; c < 7; c++) begin
         @(negedge clk);
         enrv[c]  = bus.fifo_enr;
         donev[c] = done;
         tvv[c]   = bus.m_tvalid;
      end
      check("basic_enr_cycles",    {25'd0, enrv},  32'b0010101);
      check("basic_tvalid_cycles", {25'd0, tvv},   32'b0101010);
      check("basic_done_cycle",    {25'd0, donev}, 32'b1000000);
      check("basic_count", {16'd0, count}, 32'd3);
      tick();

      // backpressure: only two pops, head word held stable
      bus.m_tready = 1'b0;
      push_word(8'hA1, 1'b0, 1'b1);
      push_word(8'hA2, 1'b0, 1'b1);
      push_word(8'hA3, 1'b0, 1'b1);
      push_word(8'hA4, 1'b1, 1'b1);
      tick();
      tick();
      do_start(16'd4);
      pops    = 0;
      stable  = 1'b1;
      first_d = '0;
      any     = 1'b0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (bus.fifo_enr) pops++;
         if (bus.m_tvalid) begin
            if (!any) first_d = bus.m_tdata;
            else if (bus.m_tdata !== first_d) stable = 1'b0;
            any = 1'b1;
         end else if (any) begin
            stable = 1'b0;
         end
      end
      check("bp_pops", pops, 32'd2);
      check("bp_tvalid", {31'd0, bus.m_tvalid}, 32'd1);
      check("bp_head", {24'd0, bus.m_tdata}, 32'hA1);
      check("bp_stable", {31'd0, stable}, 32'd1);
      tick();
      bus.m_tready = 1'b1;
      wait_done("bp_done", 40);
      check("bp_count", {16'd0, count}, 32'd4);
      check("bp_all_beats", exp_q.size(), 32'd0);

      // empty FIFO stall
      do_start(16'd2);
      any      = 1'b0;
      all_busy = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         any      = any | bus.fifo_enr;
         all_busy = all_busy & busy;
      end
      check("stall_no_enr", {31'd0, any}, 32'd0);
      check("stall_busy", {31'd0, all_busy}, 32'd1);
      tick();
      push_word(8'hA5, 1'b0, 1'b1);
      push_word(8'h5A, 1'b1, 1'b1);
      wait_done("stall_done", 30);
      check("stall_count", {16'd0, count}, 32'd2);

      // zero length
      do_start(16'd0);
      any = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         zdone[c] = done;
         any = any | bus.fifo_enr | bus.m_tvalid;
      end
      check("zero_done_cycle", {29'd0, zdone}, 32'b001);
      check("zero_no_activity", {31'd0, any}, 32'd0);
      check("zero_count", {16'd0, count}, 32'd0);
      check("zero_idle", {31'd0, busy}, 32'd0);
      tick();

      // abort after three accepted beats
      for (int i = 1; i <= 8; i++) push_word(DATA_W'(i), 1'b0, i <= 3);
      tick();
      tick();
      do_start(16'd8);
      seen3 = 1'b0;
      for (int c = 0; c < 40 && !seen3; c++) begin
         @(negedge clk);
         if (count == 16'd3) seen3 = 1'b1;
      end
      check("abort_reach3", {31'd0, seen3}, 32'd1);
      tick();
      abort = 1'b1;
      bus.m_tready = 1'b0;
      tick();
      abort = 1'b0;
      @(negedge clk);
      check("abort_busy", {31'd0, busy}, 32'd0);
      check("abort_tvalid", {31'd0, bus.m_tvalid}, 32'd0);
      check("abort_count", {16'd0, count}, 32'd3);
      any = done;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         any = any | done;
      end
      check("abort_no_done", {31'd0, any}, 32'd0);
      check("abort_beats", exp_q.size(), 32'd0);
      tick();
      clear_fifo();
      bus.m_tready = 1'b1;
      push_word(8'h77, 1'b1, 1'b1);
      tick();
      tick();
      do_start(16'd1);
      wait_done("after_abort_done", 20);
      check("after_abort_count", {16'd0, count}, 32'd1);

      // async reset mid-run, applied between clock edges
      bus.m_tready = 1'b0;
      push_word(8'hB1, 1'b0, 1'b0);
      push_word(8'hB2, 1'b0, 1'b0);
      push_word(8'hB3, 1'b0, 1'b0);
      tick();
      tick();
      do_start(16'd3);
      tick();
      tick();
      #2;
      check("prerst_enr", {31'd0, bus.fifo_enr}, 32'd1);
      check("prerst_tvalid", {31'd0, bus.m_tvalid}, 32'd1);
      rst = 1'b0;
      #1;
      check("arst_busy", {31'd0, busy}, 32'd0);
      check("arst_tvalid", {31'd0, bus.m_tvalid}, 32'd0);
      check("arst_enr", {31'd0, bus.fifo_enr}, 32'd0);
      tick();
      rst = 1'b1;
      @(negedge clk);
      check("arst_count", {16'd0, count}, 32'd0);
      check("arst_idle", {31'd0, busy}, 32'd0);
      tick();
      clear_fifo();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/fifo_stream_reader.md
Name: fifo_stream_reader

Overview:
- Read-side controller for the shift-register FIFO in the accelerator kernel datapath.
- Pops a programmed number of words via the FIFO's enr/valid/dataout port and presents them as a valid/ready stream, with tlast on the final word, for the HWPE streamer.
- Holds a 2-entry output skid buffer, a pop-pacing rule and a transfer counter, controlled by a start/len/abort command interface.

Parameters:
DATA_W, 8, width of FIFO word and stream data; must equal the FIFO's size.
LEN_W, 16, width of transfer length and word counter.

Ports:
clk  in  1  clock
rst  in  1  reset
start  in  1  one-cycle pulse; latch len and begin transfer (ignored unless IDLE)
len  in  LEN_W  number of words to transfer; sampled on start
abort  in  1  cancel current transfer
busy  out  1  high while not IDLE
done  out  1  one-cycle pulse when the last word is accepted downstream
count  out  LEN_W  words accepted downstream in current/last transfer
fifo_valid  in  1  FIFO non-empty flag (registered in FIFO)
fifo_dataout  in  DATA_W  FIFO head word
fifo_enr  out  1  FIFO pop strobe
m_tdata  out  DATA_W  stream data
m_tvalid  out  1  stream valid
m_tready  in  1  stream ready
m_tlast  out  1  marks final word of transfer

Behaviour:
- Reset: rst is asynchronous, active-low; clock is clk. All state registers clear on reset, independent of clk. In reset: state=IDLE, busy=0, done=0, count=0, fifo_enr=0, m_tvalid=0, m_tlast=0, m_tdata=0, skid buffer empty, issued=0, pop_d=0.
- FSM: IDLE, RUN, DRAIN, DONE.
  - IDLE: start with len!=0 -> RUN, latch len, clear count and issued. start with len==0 -> DONE directly (done pulses, no pop, no stream beat).
  - RUN: issue pops until issued==len, then -> DRAIN.
  - DRAIN: wait until the skid buffer is empty and the last beat is accepted, then -> DONE.
  - DONE: done=1 for exactly one cycle, then -> IDLE. count holds its value until the next start.
- Pop rule (combinational): fifo_enr = (state==RUN) && fifo_valid && !pop_d && (issued<len) && (occupancy + pending_pop < 2).
  - pop_d is fifo_enr delayed one cycle. It enforces a 1-cycle gap after every pop because the FIFO's valid lags its occupancy by a cycle. Maximum rate is 1 word per 2 cycles.
- Capture: fifo_dataout is sampled on the same clk edge at which fifo_enr is high, and written into the skid buffer at the tail. issued increments on each pop.
- Stream:
  - m_tvalid = buffer non-empty; m_tdata = buffer head.
  - A beat transfers when m_tvalid && m_tready; the head is then removed and count increments.
  - m_tlast = m_tvalid && (count == len-1).
  - m_tdata/m_tvalid/m_tlast hold stable while m_tvalid && !m_tready.
- Latency: fifo_enr in cycle N -> m_tvalid in cycle N+1. Last beat accepted in cycle M -> done in cycle M+1.
- Simultaneous push and pop of the skid buffer in one cycle is legal. Occupancy is unchanged and order is preserved.
- Occupancy never exceeds 2. With the buffer full and m_tready=0, fifo_enr stays 0.
- abort (any non-IDLE state): on the next edge go to IDLE, flush the skid buffer, m_tvalid=0, fifo_enr=0, no done pulse. Words already popped are discarded. abort in IDLE has no effect. abort takes priority over start in the same cycle.
- start while busy is ignored.
- Arithmetic: count and issued are LEN_W unsigned. len = 2^LEN_W-1 is legal; no wrap occurs because counting stops at len.
- Reset mid-transfer: immediate return to reset values. The FIFO contents are not this block's concern.

Test Plan:
- Basic: FIFO preloaded with 0x11,0x22,0x33; start len=3, m_tready=1 -> fifo_enr pulses at cycles 1,3,5. Beats 0x11,0x22,0x33 appear at cycles 2,4,6, with tlast only on 0x33. done at cycle 7; count=3.
- Backpressure: len=4, m_tready=0 for 10 cycles -> exactly 2 pops, m_tvalid=1 holding the first word stable. Release m_tready -> all 4 words arrive in order, no loss or duplication.
- Empty FIFO stall: start len=2 with fifo_valid=0 for 5 cycles -> no fifo_enr, busy=1. Then push 0xA5,0x5A -> both streamed, tlast on 0x5A, done pulse.
- Zero length: start len=0 -> done pulses one cycle later, fifo_enr never asserted, m_tvalid never asserted, count=0.
- Abort: len=8, abort after 3 beats accepted -> next cycle busy=0, m_tvalid=0, no done, count=3. A subsequent start len=1 proceeds normally.
- Async reset mid-run: drive rst low between clk edges during RUN -> busy, m_tvalid and fifo_enr drop immediately; count=0 after reset release.
